seq_shift_add_multiplier: RTL and testbench
===========================================

Name: seq_shift_add_multiplier

Overview:
- Parametrised, iterative shift-and-add successor to the team's 6-bit combinational array multiplier.
- Computes one WIDTH x WIDTH product per transaction over WIDTH clock cycles, reusing a single WIDTH-bit adder.
- Adds a per-operation signed/unsigned mode and a valid/ready handshake on input and output.
- Used where the area of the full array is not affordable; sits between a register-file read stage and a result writeback stage.

Parameters:
- WIDTH, 6, operand width in bits; legal range 2..32. The product is 2*WIDTH bits.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  synchronous active-low reset
- in_valid  input  1  operands and mode are valid this cycle
- in_ready  output  1  block can accept operands (high only in IDLE)
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- signed_mode  input  1  1 = two's-complement operands and product; 0 = unsigned
- busy  output  1  high in BUSY state
- out_valid  output  1  product valid; held until accepted
- out_ready  input  1  consumer accepts the product
- p  output  2*WIDTH  product

Behaviour:
- Reset:
  - Applies when rst_n=0 at a rising clk edge; overrides all other inputs, including mid-operation.
  - State goes to IDLE; in_ready=1, busy=0, out_valid=0, p=0.
  - The internal accumulator, operand registers and counter clear to 0.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready=1.
  - On an edge with in_valid=1:
    - Capture |a|, |b| and neg = signed_mode & (a[MSB]^b[MSB]).
    - Magnitudes are taken only when signed_mode=1; otherwise the raw values are captured.
    - Clear the accumulator, set count=0, and go to BUSY.
- BUSY:
  - in_ready=0, busy=1. in_valid and all operand inputs are ignored.
  - Each edge: if the multiplier LSB is 1, add the multiplicand into the upper half of the accumulator, keeping the carry.
  - Then shift the {carry, accumulator} pair right by 1 and increment count.
  - After the WIDTH-th iteration, load p = neg ? -acc : acc (2*WIDTH-bit two's complement) and go to DONE.
- DONE:
  - out_valid=1; p stable.
  - On an edge with out_ready=1, drop out_valid and go to IDLE.
  - in_ready stays 0 in DONE, so there is no accept on the same edge as the output handshake.
- Latency and throughput:
  - out_valid rises exactly WIDTH edges after the accepting edge.
  - Minimum issue interval is WIDTH+2 cycles (accept, WIDTH iterations, one DONE cycle with out_ready=1).
- p holds its last value in IDLE and BUSY until overwritten on entry to DONE.
- Arithmetic and width rules:
  - Unsigned: p = a*b, exact in 2*WIDTH bits.
  - Signed: p = a*b as 2*WIDTH-bit two's complement, exact for all inputs.
  - The most-negative case (-2^(WIDTH-1) squared) must be correct, because its magnitude fits in WIDTH unsigned bits.
  - A zero operand still takes the full WIDTH cycles; there is no early termination.
  - A negative zero product yields 0 (negating 0 is 0).
- Backpressure: out_ready held low keeps DONE, out_valid and p indefinitely.
- Mode and operand changes after the accepting edge have no effect on the transaction in flight.

Test Plan:
- WIDTH=6, unsigned, a=6'b111111, b=6'b111111 -> out_valid rises 6 edges after accept; p=12'hF81 (3969).
- Unsigned a=6'b110101 (53), b=6'b010110 (22) -> p=12'h48E (1166). Then a=0, b=0 -> p=0, still 6-cycle latency.
- Signed a=6'b100000 (-32), b=6'b100000 (-32) -> p=12'h400 (1024). Signed a=6'b111111 (-1), b=6'b000101 (5) -> p=12'hFFB (-5).
- Backpressure and handshake:
  - Hold out_ready=0 for 10 cycles after out_valid -> p and out_valid stable, in_ready=0.
  - Toggle a, b and in_valid during BUSY -> result unaffected.
  - Assert out_ready -> IDLE next edge; back-to-back accept gives a 8-cycle issue interval.
- Reset mid-operation: rst_n=0 at the 3rd BUSY cycle -> next edge in IDLE, busy=0, out_valid=0, p=0. A new op 7*9 unsigned then gives p=63.
- Random sweep: 1000 random a, b and signed_mode values at WIDTH=6 and WIDTH=16, compared against a behavioural model (signed and unsigned reference product).

Source files
------------

// File: rtl/seq_shift_add_multiplier.sv
// Iterative shift-and-add multiplier: one WIDTH x WIDTH product per transaction over WIDTH cycles,
// using a single WIDTH-bit adder, with signed/unsigned mode and valid/ready handshakes.
module seq_shift_add_multiplier #(
  parameter int WIDTH = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               signed_mode,
  output logic               busy,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] p
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] p_q, p_d;
  logic [CW-1:0]      count_q, count_d;
  logic               neg_q, neg_d;

  logic [WIDTH:0]     sum;
  logic [2*WIDTH-1:0] acc_shifted;

  always_comb begin
    state_d  = state_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    p_d      = p_q;
    count_d  = count_q;
    neg_d    = neg_q;

    // Add into the upper half keeping the carry, then shift {carry, acc} right by one.
    sum         = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (mplier_q[0] ? {1'b0, mcand_q} : '0);
    acc_shifted = {sum, acc_q[WIDTH-1:1]};

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Magnitude of the most-negative value still fits in WIDTH unsigned bits.
          mcand_d  = (signed_mode && a[WIDTH-1]) ? -a : a;
          mplier_d = (signed_mode && b[WIDTH-1]) ? -b : b;
          neg_d    = signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
          acc_d    = '0;
          count_d  = '0;
          state_d  = BUSY;
        end
      end
      BUSY: begin
        acc_d    = acc_shifted;
        mplier_d = mplier_q >> 1;
        count_d  = count_q + CW'(1);
        if (count_q == CW'(WIDTH - 1)) begin
          p_d     = neg_q ? -acc_shifted : acc_shifted;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      p_q      <= '0;
      count_q  <= '0;
      neg_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      p_q      <= p_d;
      count_q  <= count_d;
      neg_q    <= neg_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q == BUSY);
  assign out_valid = (state_q == DONE);
  assign p         = p_q;

endmodule

// File: tb/tb_seq_shift_add_multiplier.sv
// Bench for seq_shift_add_multiplier: cycle-level behavioural model for WIDTH=6 plus a
// handshake-level random sweep on a WIDTH=16 instance.
module tb_seq_shift_add_multiplier;

  localparam int W  = 6;
  localparam int W2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // WIDTH=6 instance
  logic             rst_n, in_valid, signed_mode, out_ready;
  logic [W-1:0]     a, b;
  logic             in_ready, busy, out_valid;
  logic [2*W-1:0]   p;

  // WIDTH=16 instance
  logic             rst16_n, in_valid16, signed_mode16, out_ready16;
  logic [W2-1:0]    a16, b16;
  logic             in_ready16, busy16, out_valid16;
  logic [2*W2-1:0]  p16;

  seq_shift_add_multiplier #(.WIDTH(W)) dut6 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .signed_mode(signed_mode), .busy(busy),
    .out_valid(out_valid), .out_ready(out_ready), .p(p)
  );

  seq_shift_add_multiplier #(.WIDTH(W2)) dut16 (
    .clk(clk), .rst_n(rst16_n), .in_valid(in_valid16), .in_ready(in_ready16),
    .a(a16), .b(b16), .signed_mode(signed_mode16), .busy(busy16),
    .out_valid(out_valid16), .out_ready(out_ready16), .p(p16)
  );

  int checks = 0;
  int errors = 0;
  bit started = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Reference product from plain integer arithmetic, truncated to 2*w bits.
  function automatic longint ref_prod(input longint x_in, input longint y_in, input bit sm, input int w);
    longint x, y, r;
    x = x_in;
    y = y_in;
    if (sm) begin
      if (x[w-1]) x = x - (longint'(1) << w);
      if (y[w-1]) y = y - (longint'(1) << w);
    end
    r = x * y;
    return r & ((longint'(1) << (2 * w)) - 1);
  endfunction

  // Transaction-level model of the WIDTH=6 instance: accept when idle, result WIDTH edges later,
  // result held until taken.
  int             m_left = 0;
  bit             m_valid = 1'b0;
  logic [2*W-1:0] m_p = '0;
  logic [2*W-1:0] m_prod = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_left  <= 0;
      m_valid <= 1'b0;
      m_p     <= '0;
    end else if (m_valid) begin
      if (out_ready) m_valid <= 1'b0;
    end else if (m_left > 0) begin
      m_left <= m_left - 1;
      if (m_left == 1) begin
        m_valid <= 1'b1;
        m_p     <= m_prod;
      end
    end else if (in_valid) begin
      m_left <= W;
      m_prod <= (2*W)'(ref_prod(longint'(a), longint'(b), signed_mode, W));
    end
  end

  always @(negedge clk) begin
    if (started) begin
      check("cyc_in_ready", in_ready, (!m_valid && m_left == 0));
      check("cyc_busy", busy, (m_left > 0));
      check("cyc_out_valid", out_valid, m_valid);
      check("cyc_p", p, m_p);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic op6(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input bit sm,
                     input logic [2*W-1:0] exp, input int hold, input bit scramble, input string name);
    int lat;
    a = ta; b = tb_v; signed_mode = sm; in_valid = 1'b1; out_ready = 1'b0;
    check({name, "_in_ready"}, in_ready, 1);
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      if (scramble) begin
        a = W'($urandom); b = W'($urandom);
        signed_mode = 1'($urandom); in_valid = 1'($urandom);
      end
      tick();
      lat++;
    end
    in_valid = 1'b0;
    check({name, "_latency"}, lat, W);
    check({name, "_p"}, p, exp);
    for (int i = 0; i < hold; i++) begin
      tick();
      check({name, "_hold_p"}, p, exp);
      check({name, "_hold_valid"}, out_valid, 1);
      check({name, "_hold_in_ready"}, in_ready, 0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_after_valid"}, out_valid, 0);
    check({name, "_after_in_ready"}, in_ready, 1);
    $display("op %s: a=%0d b=%0d signed=%0d p=0x%0h expected=0x%0h latency=%0d", name, ta, tb_v, sm, p, exp, lat);
  endtask

  task automatic run_dut6();
    int first, gap;
    logic [W-1:0] ra, rb;
    bit rs;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; signed_mode = 1'b0;
    tick(); tick();
    started = 1'b1;
    tick();
    check("reset_in_ready", in_ready, 1);
    check("reset_busy", busy, 0);
    check("reset_out_valid", out_valid, 0);
    check("reset_p", p, 0);
    rst_n = 1'b1;

    op6(6'b111111, 6'b111111, 1'b0, 12'hF81, 0, 1'b0, "uu_max");
    op6(6'b110101, 6'b010110, 1'b0, 12'h48E, 0, 1'b0, "uu_53x22");
    op6(6'd0, 6'd0, 1'b0, 12'h000, 0, 1'b0, "uu_zero");
    op6(6'b100000, 6'b100000, 1'b1, 12'h400, 0, 1'b0, "ss_minneg_sq");
    op6(6'b111111, 6'b000101, 1'b1, 12'hFFB, 0, 1'b0, "ss_m1x5");
    op6(6'b111111, 6'b000000, 1'b1, 12'h000, 0, 1'b0, "ss_neg_zero");
    op6(6'd10, 6'd13, 1'b0, 12'd130, 10, 1'b1, "backpressure");

    // Back-to-back issue with in_valid and out_ready held high.
    a = 6'd3; b = 6'd5; signed_mode = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    first = -1; gap = -1;
    for (int i = 0; i < 30 && gap < 0; i++) begin
      if (in_ready) begin
        if (first < 0) first = i;
        else gap = i - first;
      end
      tick();
    end
    in_valid = 1'b0;
    repeat (10) tick();
    out_ready = 1'b0;
    check("issue_interval", gap, W + 2);
    $display("op issue_interval: gap=%0d expected=%0d", gap, W + 2);

    // Reset during the third BUSY cycle.
    a = 6'd21; b = 6'd17; signed_mode = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1);
    check("midrst_busy", busy, 0);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_p", p, 0);
    $display("op mid_reset: busy=%0d out_valid=%0d p=0x%0h", busy, out_valid, p);
    op6(6'd7, 6'd9, 1'b0, 12'd63, 0, 1'b0, "after_reset_7x9");

    for (int n = 0; n < 1000; n++) begin
      ra = W'($urandom); rb = W'($urandom); rs = 1'($urandom);
      op6(ra, rb, rs, (2*W)'(ref_prod(longint'(ra), longint'(rb), rs, W)),
          int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)), "rand6");
    end
  endtask

  task automatic run_dut16();
    int lat;
    logic [W2-1:0] ra, rb;
    bit rs;
    logic [2*W2-1:0] exp;
    rst16_n = 1'b0; in_valid16 = 1'b0; out_ready16 = 1'b0; a16 = '0; b16 = '0; signed_mode16 = 1'b0;
    tick(); tick();
    check("reset16_p", p16, 0);
    check("reset16_in_ready", in_ready16, 1);
    rst16_n = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      ra = W2'($urandom); rb = W2'($urandom); rs = 1'($urandom);
      if (n == 0) begin ra = 16'h8000; rb = 16'h8000; rs = 1'b1; end
      exp = (2*W2)'(ref_prod(longint'(ra), longint'(rb), rs, W2));
      a16 = ra; b16 = rb; signed_mode16 = rs; in_valid16 = 1'b1; out_ready16 = 1'b0;
      tick();
      in_valid16 = 1'b0;
      lat = 0;
      while (!out_valid16 && lat < 100) begin
        a16 = W2'($urandom);
        tick();
        lat++;
      end
      check("rand16_latency", lat, W2);
      check("rand16_p", p16, exp);
      $display("op rand16: a=0x%0h b=0x%0h signed=%0d p=0x%0h expected=0x%0h", ra, rb, rs, p16, exp);
      out_ready16 = 1'b1;
      tick();
      out_ready16 = 1'b0;
    end
  endtask

  initial begin
    check("model_pin_uu_max", ref_prod(63, 63, 1'b0, W), 3969);
    check("model_pin_ss_minneg", ref_prod(32, 32, 1'b1, W), 12'h400);
    check("model_pin_ss_m1x5", ref_prod(63, 5, 1'b1, W), 12'hFFB);
    check("model_pin_uu_53x22", ref_prod(53, 22, 1'b0, W), 12'h48E);
    fork
      run_dut6();
      run_dut16();
    join
    started = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
    $fatal(1, "watchdog expired");
  end

endmodule
